// File: rtl/dmem_resp_if.sv
// Load/store bus between the core's MEM stage (master) and dmem_resp (slave).
interface dmem_resp_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output req_i, we_i, addr_i, be_i, wdata_i,
        input  ack_o, rdata_o, err_o, busy_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, wdata_i,
        output ack_o, rdata_o, err_o, busy_o
    );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: word RAM with byte-lane stores, one ack per request.
// Define DMEM_WAIT_EN to insert WAIT_CYCLES wait states before each ack.
module dmem_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic         clk,
    input logic         rst,
    dmem_resp_if.slave  bus
);
    localparam int unsigned IW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RESP = 2'd2;
`ifdef DMEM_WAIT_EN
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`endif

    logic [1:0]    state;
    logic          we_q;
    logic          err_q;
    logic [IW-1:0] idx_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem [DEPTH_WORDS];
`ifdef DMEM_WAIT_EN
    logic [3:0]    wait_cnt;
`endif

    logic [IW-1:0] req_idx;
    logic          be_ok;
    logic          addr_hi;
    logic          req_err;

    assign req_idx = bus.addr_i[IW+1:2];

    always_comb begin
        be_ok = 1'b0;
        case (bus.be_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
            default:                   be_ok = 1'b0;
        endcase
        addr_hi = (bus.addr_i >> (IW + 2)) != 32'd0;
        req_err = addr_hi || !be_ok;
    end

    // rdata_q is loaded on the edge that enters RESP so it is valid with ack_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef DMEM_WAIT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_i) begin
                        we_q    <= bus.we_i;
                        err_q   <= req_err;
                        idx_q   <= req_idx;
                        be_q    <= bus.be_i;
                        wdata_q <= bus.wdata_i;
`ifdef DMEM_WAIT_EN
                        wait_cnt <= WAIT_INIT;
                        if (WAIT_CYCLES > 0) begin
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_RESP;
                            if (!bus.we_i && !req_err)
                                rdata_q <= mem[req_idx];
                        end
`else
                        state <= ST_RESP;
                        if (!bus.we_i && !req_err)
                            rdata_q <= mem[req_idx];
`endif
                    end
                end
`ifdef DMEM_WAIT_EN
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_RESP;
                        if (!we_q && !err_q)
                            rdata_q <= mem[idx_q];
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
`endif
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Store commits in RESP; a reset in that cycle aborts it.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_RESP && we_q && !err_q) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be_q[k])
                    mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
            end
        end
    end

    assign bus.ack_o   = (state == ST_RESP) && !rst;
    assign bus.err_o   = bus.ack_o && err_q;
    assign bus.busy_o  = (state != ST_IDLE);
    assign bus.rdata_o = rdata_q;
endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp (works with or without DMEM_WAIT_EN).
module tb_dmem_resp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned checks = 0;
    int unsigned errors = 0;

`ifdef DMEM_WAIT_EN
    localparam int unsigned EXP_LAT = 3;
`else
    localparam int unsigned EXP_LAT = 1;
`endif

    dmem_resp_if bus ();

    dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] got_rdata;
    logic        got_err;

    // Drive one request, wait (bounded) for ack, check latency and busy, then release.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata);
        int unsigned lat;
        logic        seen;
        lat  = 0;
        seen = 1'b0;
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.be_i    = be;
        bus.wdata_i = wdata;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.ack_o) begin
                seen      = 1'b1;
                got_rdata = bus.rdata_o;
                got_err   = bus.err_o;
            end
            check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
        end
        check({tag, "_acked"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, lat, EXP_LAT);
        @(posedge clk);
        #1;
        bus.req_i = 1'b0;
    endtask

    initial begin
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.be_i    = '0;
        bus.wdata_i = '0;

        // Reset for three cycles
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ack",   32'(bus.ack_o),  32'd0);
        check("rst_err",   32'(bus.err_o),  32'd0);
        check("rst_busy",  32'(bus.busy_o), 32'd0);
        check("rst_rdata", bus.rdata_o,     32'h0);
        repeat (3) begin
            @(negedge clk);
            check("idle_noack", 32'(bus.ack_o), 32'd0);
        end
        @(posedge clk);
        #1;

        // Full-word store and load back
        access("st10", 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF);
        check("st10_err", 32'(got_err), 32'd0);
        access("ld10", 1'b0, 32'h10, 4'b1111, 32'h0);
        check("ld10_data", got_rdata, 32'hDEADBEEF);
        check("ld10_err", 32'(got_err), 32'd0);
        @(negedge clk);
        check("single_ack", 32'(bus.ack_o), 32'd0);
        @(posedge clk);
        #1;

        // Single-lane store, then illegal lane pattern
        access("st10b1", 1'b1, 32'h10, 4'b0010, 32'h0000AA00);
        access("ld10b", 1'b0, 32'h10, 4'b0000 | 4'b1111, 32'h0);
        check("ld10b_data", got_rdata, 32'hDEADAAEF);
        access("st10bad", 1'b1, 32'h10, 4'b0101, 32'h11223344);
        check("st10bad_err", 32'(got_err), 32'd1);
        access("ld10c", 1'b0, 32'h10, 4'b1111, 32'h0);
        check("ld10c_data", got_rdata, 32'hDEADAAEF);
        check("ld10c_err", 32'(got_err), 32'd0);

        // Half-word and byte stores combine on one word
        access("st14a", 1'b1, 32'h14, 4'b1111, 32'h00000000);
        access("st14b", 1'b1, 32'h14, 4'b1100, 32'hCAFE1111);
        access("st14c", 1'b1, 32'h14, 4'b0001, 32'h22222277);
        access("ld14", 1'b0, 32'h14, 4'b0011, 32'h0);
        check("ld14_data", got_rdata, 32'hCAFE0077);

        // Out-of-range address: errored, no write, rdata held
        access("st0", 1'b1, 32'h0, 4'b1111, 32'h12345678);
        access("stoor", 1'b1, 32'h00001000, 4'b1111, 32'hFFFFFFFF);
        check("stoor_err", 32'(got_err), 32'd1);
        access("ld0", 1'b0, 32'h0, 4'b1111, 32'h0);
        check("ld0_data", got_rdata, 32'h12345678);
        access("ldoor", 1'b0, 32'h00001000, 4'b1111, 32'h0);
        check("ldoor_err", 32'(got_err), 32'd1);
        check("ldoor_hold", got_rdata, 32'h12345678);
        access("ldbadbe", 1'b0, 32'h10, 4'b0110, 32'h0);
        check("ldbadbe_err", 32'(got_err), 32'd1);
        check("ldbadbe_hold", got_rdata, 32'h12345678);

        // Reset during an in-flight store aborts it
        access("st20", 1'b1, 32'h20, 4'b1111, 32'hA5A5A5A5);
        bus.req_i   = 1'b1;
        bus.we_i    = 1'b1;
        bus.addr_i  = 32'h20;
        bus.be_i    = 4'b1111;
        bus.wdata_i = 32'h5A5A5A5A;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(bus.busy_o), 32'd1);
        check("abort_noack", 32'(bus.ack_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_idle_ack", 32'(bus.ack_o), 32'd0);
            check("abort_idle_busy", 32'(bus.busy_o), 32'd0);
        end
        @(posedge clk);
        #1;
        access("ld20", 1'b0, 32'h20, 4'b1111, 32'h0);
        check("ld20_data", got_rdata, 32'hA5A5A5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
